usb_bitstuff_tx: RTL and testbench

- Transmit-side serializer and bit stuffer; sits directly upstream of the NRZI encoder in the CRC/NRZI transmit path.
- Accepts packet bytes over a valid/ready handshake and emits one bit per clock, LSB first.
- After STUFF_LEN consecutive 1 data bits, inserts a 0 (USB bit stuffing) so the NRZI line is guaranteed a transition.
- Drives constant 1 when idle, so the encoder holds its line level.

---
 rtl/usb_bitstuff_tx.sv | 144 ++++++++++++++
 tb/tb_usb_bitstuff_tx.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/usb_bitstuff_tx.sv
// USB transmit serializer with bit stuffing: bytes in over valid/ready, one bit per clock out, LSB first.
// Optional trailing stuff bit after the final data bit is enabled with `define USB_BITSTUFF_TAIL_EN.
module usb_bitstuff_tx #(
  parameter int STUFF_LEN = 6,
  parameter int DATA_W    = 8
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              bit_o,
  output logic              bit_valid_o,
  output logic              stuffed_o,
  output logic              underrun_o
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_STUFF} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [2:0]        ones_q, ones_d;
  logic              last_q, last_d;
  logic              end_stuff_q, end_stuff_d;
  logic              bit_d, bit_valid_d, stuffed_d, underrun_d;
  logic              cur_bit, at_end, trig, byte_done, do_load, tail_en;

`ifdef USB_BITSTUFF_TAIL_EN
  assign tail_en = 1'b1;
`else
  assign tail_en = 1'b0;
`endif

  assign cur_bit = shreg_q[idx_q];
  assign at_end  = (idx_q == IDX_W'(DATA_W - 1));
  assign trig    = (state_q == S_DATA) && cur_bit && (ones_q == 3'(STUFF_LEN - 1));

  // A stuff pending on the final bit holds ready_o off until the stuff cycle itself.
  assign ready_o = (state_q == S_IDLE) ||
                   ((state_q == S_DATA) && at_end && !trig && !last_q) ||
                   ((state_q == S_STUFF) && end_stuff_q && !last_q);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    ones_d      = ones_q;
    last_d      = last_q;
    end_stuff_d = end_stuff_q;
    underrun_d  = 1'b0;
    byte_done   = 1'b0;
    do_load     = 1'b0;

    case (state_q)
      S_IDLE: begin
        ones_d  = '0;
        do_load = valid_i;
      end
      S_DATA: begin
        ones_d = cur_bit ? ones_q + 3'd1 : '0;
        if (trig) begin
          ones_d = '0;
          if (at_end && last_q && !tail_en) begin
            state_d = S_IDLE;
          end else begin
            state_d     = S_STUFF;
            end_stuff_d = at_end;
          end
        end else if (!at_end) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          byte_done = 1'b1;
        end
      end
      S_STUFF: begin
        ones_d = '0;
        if (end_stuff_q) begin
          byte_done = 1'b1;
        end else begin
          state_d = S_DATA;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (byte_done) begin
      if (last_q) begin
        state_d = S_IDLE;
      end else if (valid_i) begin
        do_load = 1'b1;
      end else begin
        underrun_d = 1'b1;
        state_d    = S_IDLE;
      end
    end

    if (do_load) begin
      state_d     = S_DATA;
      shreg_d     = data_i;
      last_d      = last_i;
      idx_d       = '0;
      end_stuff_d = 1'b0;
    end

    if (state_d == S_IDLE) ones_d = '0;

    // Outputs are registered: compute what the next cycle will present.
    bit_valid_d = (state_d != S_IDLE);
    stuffed_d   = (state_d == S_STUFF);
    bit_d       = (state_d == S_DATA) ? shreg_d[idx_d] : (state_d != S_STUFF);
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      idx_q       <= '0;
      ones_q      <= '0;
      last_q      <= 1'b0;
      end_stuff_q <= 1'b0;
      bit_o       <= 1'b1;
      bit_valid_o <= 1'b0;
      stuffed_o   <= 1'b0;
      underrun_o  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      ones_q      <= ones_d;
      last_q      <= last_d;
      end_stuff_q <= end_stuff_d;
      bit_o       <= bit_d;
      bit_valid_o <= bit_valid_d;
      stuffed_o   <= stuffed_d;
      underrun_o  <= underrun_d;
    end
  end

endmodule

// File: tb/tb_usb_bitstuff_tx.sv
// Directed self-checking bench for usb_bitstuff_tx; honours `define USB_BITSTUFF_TAIL_EN.
module tb_usb_bitstuff_tx;

  logic       clk_i = 1'b0;
  logic       resetn_i;
  logic [7:0] data_i;
  logic       last_i;
  logic       valid_i;
  logic       ready_o, bit_o, bit_valid_o, stuffed_o, underrun_o;

  logic [7:0] nxt_data;
  logic       nxt_last;
  logic       nxt_valid;

  int total = 0;
  int bad   = 0;

  usb_bitstuff_tx #(.STUFF_LEN(6), .DATA_W(8)) dut (
    .clk_i       (clk_i),
    .resetn_i    (resetn_i),
    .data_i      (data_i),
    .last_i      (last_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .bit_o       (bit_o),
    .bit_valid_o (bit_valid_o),
    .stuffed_o   (stuffed_o),
    .underrun_o  (underrun_o)
  );

  always #5 clk_i = ~clk_i;

  // Status vector order: {bit_valid_o, bit_o, stuffed_o, underrun_o, ready_o}
  function automatic logic [4:0] status();
    return {bit_valid_o, bit_o, stuffed_o, underrun_o, ready_o};
  endfunction

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one clock; if a byte is accepted on this edge, present the queued next byte.
  task automatic step();
    logic acc;
    acc = ready_o && valid_i && resetn_i;
    @(posedge clk_i);
    #1;
    if (acc) begin
      data_i    = nxt_data;
      last_i    = nxt_last;
      valid_i   = nxt_valid;
      nxt_valid = 1'b0;
    end
  endtask

  task automatic start(input logic [7:0] d, input logic l,
                       input logic [7:0] nd, input logic nl, input logic nv);
    data_i    = d;
    last_i    = l;
    valid_i   = 1'b1;
    nxt_data  = nd;
    nxt_last  = nl;
    nxt_valid = nv;
    step();
  endtask

  task automatic stream(input string tag, input logic [31:0] bits, input logic [31:0] stf,
                        input logic [31:0] rdy, input int n);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s[%0d]", tag, k), status(), {1'b1, bits[k], stf[k], 1'b0, rdy[k]});
      step();
    end
  endtask

  initial begin
    resetn_i  = 1'b0;
    data_i    = '0;
    last_i    = 1'b0;
    valid_i   = 1'b0;
    nxt_data  = '0;
    nxt_last  = 1'b0;
    nxt_valid = 1'b0;
    #1;
    step();
    step();
    resetn_i = 1'b1;
    chk("reset", status(), 5'b01001);

    // 0xA5 single last byte: 1,0,1,0,0,1,0,1
    start(8'hA5, 1'b1, 8'h00, 1'b0, 1'b0);
    stream("a5", 32'hA5, 32'h0, 32'h0, 8);
    chk("a5_idle", status(), 5'b01001);

    // 0xFF then 0x00 last: six 1s, stuff, 1,1, eight 0s
    start(8'hFF, 1'b0, 8'h00, 1'b1, 1'b1);
    stream("ff00", 32'h1BF, 32'h40, 32'h100, 17);
    chk("ff00_idle", status(), 5'b01001);

    // 0xC0 then 0x0F last: run spans the byte boundary, stuff after 4th bit of byte 2
    start(8'hC0, 1'b0, 8'h0F, 1'b1, 1'b1);
    stream("c00f", 32'hFC0, 32'h1000, 32'h80, 17);
    chk("c00f_idle", status(), 5'b01001);

    // 0xFC non-last then 0x01: stuff on the last bit, ready only during the stuff cycle
    start(8'hFC, 1'b0, 8'h01, 1'b1, 1'b1);
    stream("fc01", 32'h2FC, 32'h100, 32'h100, 17);
    chk("fc01_idle", status(), 5'b01001);

    // 0xFC last: trailing stuff only in the tail build
    start(8'hFC, 1'b1, 8'h00, 1'b0, 1'b0);
`ifdef USB_BITSTUFF_TAIL_EN
    stream("fc_tail", 32'hFC, 32'h100, 32'h0, 9);
`else
    stream("fc_tail", 32'hFC, 32'h0, 32'h0, 8);
`endif
    chk("fc_idle", status(), 5'b01001);

    // 0x12 non-last with no follow-on byte: underrun pulse, back to idle
    start(8'h12, 1'b0, 8'h00, 1'b0, 1'b0);
    stream("under", 32'h12, 32'h0, 32'h80, 8);
    chk("under_pulse", status(), 5'b01011);
    step();
    chk("under_clear", status(), 5'b01001);

    // Reset while bit 3 of 0xFF is on the line
    start(8'hFF, 1'b1, 8'h00, 1'b0, 1'b0);
    stream("rst", 32'hFF, 32'h0, 32'h0, 3);
    chk("rst_bit3", status(), 5'b11000);
    resetn_i = 1'b0;
    step();
    chk("rst_now", status(), 5'b01001);
    resetn_i = 1'b1;
    step();
    chk("rst_after1", status(), 5'b01001);
    step();
    chk("rst_after2", status(), 5'b01001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
